bcd2bin: RTL and testbench

Sequential BCD-to-binary converter; the inverse of the existing bin2bcd block. It accepts a 3-digit packed BCD value {hundreds[1:0], tens[3:0], ones[3:0]} and returns the 8-bit binary equivalent. Conversion uses reverse double-dabble, one iteration per clock, with a start/busy/done handshake. It sits on the display/number-entry path, where keypad or BCD-formatted data must become binary operands.

---
 rtl/bcd2bin_pkg.sv | 24 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bcd2bin.sv | 138 +++++++++++++
 tb/tb_bcd2bin.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Digit correction constants implement the reverse double-dabble step.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ITER       = 9;
    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 8;
    localparam int ADJ_SUB    = 3;
    localparam int BCD_W      = 10;
    localparam int WORK_W     = 3 * DIGIT_W + ITER;
    localparam int CNT_W      = 4;

    // True when a 4-bit BCD digit is outside 0..9.
    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_W'(9));
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational BCD digit corrector for reverse double-dabble:
// a digit that is 8 or more after the right shift has 3 removed.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= DIGIT_W'(ADJ_THRESH)) begin
            o_digit = i_digit - DIGIT_W'(ADJ_SUB);
        end
    end

endmodule

// File: rtl/bcd2bin.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble),
// one shift/correct iteration per clock with a start/busy/done handshake.
module bcd2bin #(
    parameter int BIN_W = 8,
    parameter int ITER  = bcd2bin_pkg::ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       bcd_in,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin_out,
    output logic             ovf,
    output logic             err
);

    import bcd2bin_pkg::*;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORK_W-1:0]    r_work;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err_pend;
    logic                 r_done;
    logic [BIN_W-1:0]     r_bin;
    logic                 r_ovf;
    logic                 r_err;

    logic [WORK_W-1:0]    w_shift;
    logic [WORK_W-1:0]    w_iter;
    logic [WORK_W-1:0]    w_load;
    logic [DIGIT_W-1:0]   w_h_adj;
    logic [DIGIT_W-1:0]   w_t_adj;
    logic [DIGIT_W-1:0]   w_o_adj;
    logic                 w_load_err;
    logic                 w_last_iter;
    logic [ITER-1:0]      w_acc;

    // Layout: {h[3:0], t[3:0], o[3:0], acc[ITER-1:0]}; hundreds zero-extended.
    assign w_load     = {2'b00, bcd_in, {ITER{1'b0}}};
    assign w_load_err = digit_bad(bcd_in[7:4]) || digit_bad(bcd_in[3:0]);
    assign w_shift    = r_work >> 1;
    assign w_acc      = r_work[ITER-1:0];

    bcd_digit_adj u_adj_h (
        .i_digit (w_shift[WORK_W-1 -: DIGIT_W]),
        .o_digit (w_h_adj)
    );

    bcd_digit_adj u_adj_t (
        .i_digit (w_shift[WORK_W-1-DIGIT_W -: DIGIT_W]),
        .o_digit (w_t_adj)
    );

    bcd_digit_adj u_adj_o (
        .i_digit (w_shift[WORK_W-1-2*DIGIT_W -: DIGIT_W]),
        .o_digit (w_o_adj)
    );

    assign w_iter      = {w_h_adj, w_t_adj, w_o_adj, w_shift[ITER-1:0]};
    assign w_last_iter = (r_count == CNT_W'(ITER - 1));

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (w_last_iter) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_count    <= '0;
            r_err_pend <= 1'b0;
            r_done     <= 1'b0;
            r_bin      <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work     <= w_load;
                        r_count    <= '0;
                        r_err_pend <= w_load_err;
                    end
                end
                CONV: begin
                    r_work  <= w_iter;
                    r_count <= r_count + CNT_W'(1);
                end
                DONE: begin
                    // An invalid digit suppresses the numeric result entirely.
                    r_done <= 1'b1;
                    r_err  <= r_err_pend;
                    if (r_err_pend) begin
                        r_bin <= '0;
                        r_ovf <= 1'b0;
                    end else begin
                        r_bin <= w_acc[BIN_W-1:0];
                        r_ovf <= w_acc[ITER-1];
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done    = r_done;
    assign bin_out = r_bin;
    assign ovf     = r_ovf;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: stimulus pushes expected results and done
// cycles; a negedge monitor pops and compares on every done pulse.
module tb_bcd2bin;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] bcd_in;
    logic       busy;
    logic       done;
    logic [7:0] bin_out;
    logic       ovf;
    logic       err;

    typedef struct {
        logic [7:0] bin;
        logic       ovf;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    bcd2bin dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .ovf     (ovf),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: done=1 with empty scoreboard, bin_out=%0h (cycle %0d)", bin_out, cyc);
            end else begin
                e = sb.pop_front();
                chk("bin_out", 32'(bin_out), 32'(e.bin));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (dut.r_state == bcd2bin_pkg::DONE && dut.r_err_pend == 1'b0) begin
            chk("digits_zero_in_done", 32'(dut.r_work[20:9]), 32'h0);
        end
    end

    function automatic logic [9:0] bcd(input int v);
        return 10'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    // Called at a negedge; start is sampled at the next posedge (edge N).
    task automatic push_exp(input int val, input logic e_err, input int n_edge);
        exp_t e;
        e.err = e_err;
        e.bin = e_err ? 8'h00 : 8'(val);
        e.ovf = e_err ? 1'b0 : (val > 255);
        e.cyc = n_edge + 10;
        sb.push_back(e);
    endtask

    task automatic conv(input logic [9:0] v, input int val, input logic e_err);
        start  = 1'b1;
        bcd_in = v;
        push_exp(val, e_err, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_bin_out"}, 32'(bin_out), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal round trips
        conv(10'h165, 165, 1'b0);
        conv(10'h240, 240, 1'b0);
        conv(10'h255, 255, 1'b0);
        repeat (4) @(negedge clk);
        chk("hold_bin_out", 32'(bin_out), 32'hFF);
        chk("hold_busy", 32'(busy), 32'd0);
        conv(10'h000, 0, 1'b0);

        // Overflow
        conv(10'h399, 399, 1'b0);
        conv(10'h256, 256, 1'b0);

        // Invalid tens digit, then a valid value
        conv(10'h0A3, 0, 1'b1);
        conv(10'h042, 42, 1'b0);

        // Start while busy is dropped
        start  = 1'b1;
        bcd_in = 10'h123;
        n0 = cyc + 1;
        push_exp(123, 1'b0, n0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bcd_in = 10'h099;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset mid-conversion: no done, outputs cleared
        start  = 1'b1;
        bcd_in = bcd(200);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("midreset");
        repeat (12) @(negedge clk);
        conv(bcd(17), 17, 1'b0);

        // Start held high: three back-to-back conversions, 11 cycles apart
        start  = 1'b1;
        bcd_in = bcd(1);
        n0 = cyc + 1;
        push_exp(1, 1'b0, n0);
        @(negedge clk);
        bcd_in = bcd(99);
        push_exp(99, 1'b0, n0 + 11);
        repeat (11) @(negedge clk);
        bcd_in = bcd(250);
        push_exp(250, 1'b0, n0 + 22);
        repeat (11) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
